// File: rtl/fetch_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_sequencer
// Description : Fetch-stage controller. Owns the PC, issues one outstanding
//               instruction-memory request at a time, presents fetched
//               instructions to decode, applies branch/jump redirects and
//               discards fetches made stale by a redirect.
//               Optional feature macro: MISALIGN_TRAP_EN (misaligned redirect
//               target traps and halts fetch instead of being truncated).
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    input  logic        if_ready,
    output logic        flush_decode,
    output logic        trap_valid,
    output logic [31:0] trap_addr
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_DRAIN = 3'd4,
        S_HALT  = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic        discard_q, discard_d;
    logic        halt_pend_q, halt_pend_d;
    logic        flush_q, flush_d;
    logic        trap_valid_q, trap_valid_d;
    logic [31:0] trap_addr_q, trap_addr_d;

    logic [31:0] w_target;
    logic        w_misalign;
    logic        w_live;
    logic        w_redir;
    logic        w_trap;

    // Low target bits are dropped; a misaligned target is either truncated
    // (default build) or raises a trap (trap build).
    assign w_target = redirect_target & 32'hFFFF_FFFC;
`ifdef MISALIGN_TRAP_EN
    assign w_misalign = (redirect_target[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif
    // Redirects are ignored once fetch is halted or a halt is pending.
    assign w_live  = redirect_valid && (state_q != S_HALT) && !halt_pend_q;
    assign w_redir = w_live && !w_misalign;
    assign w_trap  = w_live && w_misalign;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_VECTOR;
            req_addr_q   <= 32'h0;
            if_pc_q      <= 32'h0;
            if_instr_q   <= 32'h0;
            discard_q    <= 1'b0;
            halt_pend_q  <= 1'b0;
            flush_q      <= 1'b0;
            trap_valid_q <= 1'b0;
            trap_addr_q  <= 32'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_addr_q   <= req_addr_d;
            if_pc_q      <= if_pc_d;
            if_instr_q   <= if_instr_d;
            discard_q    <= discard_d;
            halt_pend_q  <= halt_pend_d;
            flush_q      <= flush_d;
            trap_valid_q <= trap_valid_d;
            trap_addr_q  <= trap_addr_d;
        end
    end

    // Next-state logic: fetch sequencing, redirect handling and trap entry.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_addr_d   = req_addr_q;
        if_pc_d      = if_pc_q;
        if_instr_d   = if_instr_q;
        discard_d    = discard_q;
        halt_pend_d  = halt_pend_q;
        trap_valid_d = trap_valid_q;
        trap_addr_d  = trap_addr_q;
        flush_d      = redirect_valid && (state_q != S_HALT);

        if (w_redir) begin
            pc_d = w_target;
        end

        case (state_q)
            S_IDLE: begin
                // pc_d already reflects a same-cycle redirect
                state_d    = S_REQ;
                req_addr_d = pc_d;
            end
            S_REQ: begin
                if (imem_req_ready) begin
                    state_d = (discard_q || w_live) ? S_DRAIN : S_WAIT;
                end else if (w_live) begin
                    // keep the old address on the bus until accepted
                    discard_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (imem_resp_valid) begin
                    if (w_live) begin
                        state_d    = S_REQ;
                        req_addr_d = pc_d;
                    end else begin
                        if_instr_d = imem_resp_data;
                        if_pc_d    = req_addr_q;
                        state_d    = S_HOLD;
                    end
                end else if (w_live) begin
                    state_d = S_DRAIN;
                end
            end
            S_HOLD: begin
                // redirect wins over a simultaneous consume
                if (w_live) begin
                    state_d    = S_REQ;
                    req_addr_d = pc_d;
                end else if (if_ready) begin
                    pc_d       = pc_q + 32'd4;
                    req_addr_d = pc_q + 32'd4;
                    state_d    = S_REQ;
                end
            end
            S_DRAIN: begin
                if (imem_resp_valid) begin
                    discard_d = 1'b0;
                    if (halt_pend_q) begin
                        halt_pend_d = 1'b0;
                        state_d     = S_HALT;
                    end else begin
                        state_d    = S_REQ;
                        req_addr_d = pc_d;
                    end
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Trap: PC frozen, halt once any in-flight response has drained.
        if (w_trap) begin
            trap_valid_d = 1'b1;
            trap_addr_d  = redirect_target;
            discard_d    = 1'b0;
            if ((state_q == S_REQ   && imem_req_ready)   ||
                (state_q == S_WAIT  && !imem_resp_valid) ||
                (state_q == S_DRAIN && !imem_resp_valid)) begin
                state_d     = S_DRAIN;
                halt_pend_d = 1'b1;
            end else begin
                state_d = S_HALT;
            end
        end
    end

    assign imem_req_valid = (state_q == S_REQ);
    assign imem_req_addr  = req_addr_q;
    assign if_valid       = (state_q == S_HOLD);
    assign if_pc          = if_pc_q;
    assign if_instr       = if_instr_q;
    assign flush_decode   = flush_q;
    assign trap_valid     = trap_valid_q;
    assign trap_addr      = trap_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_pc_sequencer
// Description : Self-checking bench for fetch_pc_sequencer. A memory model
//               answers accepted requests after a programmable latency;
//               expected request addresses and presented instructions are
//               queued ahead of the stimulus and compared as they appear.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = 32'h0;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_ready;
    logic        flush_decode;
    logic        trap_valid;
    logic [31:0] trap_addr;

    int n_tests = 0;
    int n_fail  = 0;
    int n_acc   = 0;
    int n_if    = 0;
    int cyc     = 0;
    int lat     = 1;
    int mcnt    = 0;
    logic [31:0] maddr = 32'h0;
    logic [31:0] mon_e;

    logic [31:0] exp_req[$];
    logic [31:0] exp_if[$];
    int          acc_cyc[$];

    fetch_pc_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .if_valid        (if_valid),
        .if_pc           (if_pc),
        .if_instr        (if_instr),
        .if_ready        (if_ready),
        .flush_decode    (flush_decode),
        .trap_valid      (trap_valid),
        .trap_addr       (trap_addr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Poll (just after each rising edge) until if_valid, bounded.
    task automatic wait_ifv(input string tag);
        int k;
        for (k = 0; k < 60; k++) begin
            @(posedge clk); #1;
            if (if_valid) break;
        end
        check_eq(tag, 32'(k < 60), 32'd1);
    endtask

    task automatic wait_nif(input int n, input string tag);
        int k;
        for (k = 0; k < 80; k++) begin
            @(posedge clk); #1;
            if (n_if >= n) break;
        end
        check_eq(tag, 32'(k < 80), 32'd1);
    endtask

    task automatic wait_nacc(input int n, input string tag);
        int k;
        for (k = 0; k < 80; k++) begin
            @(posedge clk); #1;
            if (n_acc >= n) break;
        end
        check_eq(tag, 32'(k < 80), 32'd1);
    endtask

    // Memory model: one response per accepted request after 'lat' cycles.
    always @(posedge clk) begin
        if (reset) begin
            imem_resp_valid <= 1'b0;
            mcnt            <= 0;
        end else begin
            imem_resp_valid <= 1'b0;
            if (mcnt != 0) begin
                if (mcnt == 1) begin
                    imem_resp_valid <= 1'b1;
                    imem_resp_data  <= mem_word(maddr);
                end
                mcnt <= mcnt - 1;
            end
            if (imem_req_valid && imem_req_ready) begin
                maddr <= imem_req_addr;
                if (lat <= 1) begin
                    imem_resp_valid <= 1'b1;
                    imem_resp_data  <= mem_word(imem_req_addr);
                end else begin
                    mcnt <= lat - 1;
                end
            end
        end
    end

    // Scoreboard: compare every accepted request and consumed instruction.
    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            if (imem_req_valid && imem_req_ready) begin
                n_acc++;
                acc_cyc.push_back(cyc);
                check_eq("req_expected", 32'(exp_req.size() != 0), 32'd1);
                if (exp_req.size() != 0) begin
                    mon_e = exp_req.pop_front();
                    check_eq("req_addr", imem_req_addr, mon_e);
                end
            end
            if (if_valid && if_ready) begin
                n_if++;
                check_eq("if_expected", 32'(exp_if.size() != 0), 32'd1);
                if (exp_if.size() != 0) begin
                    mon_e = exp_if.pop_front();
                    check_eq("if_pc", if_pc, mon_e);
                    check_eq("if_instr", if_instr, mem_word(mon_e));
                end
            end
        end
    end

    initial begin
        reset           = 1'b1;
        imem_req_ready  = 1'b0;
        if_ready        = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check_eq("rst_req_addr", imem_req_addr, 32'h0);
        check_eq("rst_if_valid", 32'(if_valid), 32'd0);
        check_eq("rst_if_pc", if_pc, 32'h0);
        check_eq("rst_if_instr", if_instr, 32'h0);
        check_eq("rst_flush", 32'(flush_decode), 32'd0);
        check_eq("rst_trap", 32'(trap_valid), 32'd0);
        check_eq("rst_trap_addr", trap_addr, 32'h0);

        // Sequential fetch: 0,4,8 every 3 cycles, then 0xC held.
        exp_req.push_back(32'h0);
        exp_req.push_back(32'h4);
        exp_req.push_back(32'h8);
        exp_req.push_back(32'hC);
        exp_if.push_back(32'h0);
        exp_if.push_back(32'h4);
        exp_if.push_back(32'h8);
        @(posedge clk); #1;
        reset          = 1'b0;
        imem_req_ready = 1'b1;
        if_ready       = 1'b1;
        @(negedge clk);
        check_eq("first_cycle_idle", 32'(imem_req_valid), 32'd0);
        @(negedge clk);
        check_eq("second_cycle_req", 32'(imem_req_valid), 32'd1);
        wait_nif(3, "tmo_seq");
        if_ready = 1'b0;
        if (acc_cyc.size() >= 3) begin
            check_eq("gap_0_4", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
            check_eq("gap_4_8", 32'(acc_cyc[2] - acc_cyc[1]), 32'd3);
        end else begin
            check_eq("acc_count", 32'(acc_cyc.size()), 32'd3);
        end

        // Decode stalls 5 cycles: presentation stable, no new request.
        wait_ifv("tmo_hold");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("stall_if_valid", 32'(if_valid), 32'd1);
            check_eq("stall_if_pc", if_pc, 32'hC);
            check_eq("stall_if_instr", if_instr, mem_word(32'hC));
            check_eq("stall_no_req", 32'(imem_req_valid), 32'd0);
        end
        exp_if.push_back(32'hC);
        exp_req.push_back(32'h10);
        lat = 3;
        @(posedge clk); #1;
        if_ready = 1'b1;

        // Redirect in WAIT to 0x100; slow response must be dropped.
        wait_nacc(5, "tmo_acc10");
        redirect_valid  = 1'b1;
        redirect_target = 32'h100;
        exp_req.push_back(32'h100);
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        lat            = 1;
        @(negedge clk);
        check_eq("flush_wait_on", 32'(flush_decode), 32'd1);
        @(negedge clk);
        check_eq("flush_wait_off", 32'(flush_decode), 32'd0);

        // Redirect in HOLD with simultaneous consume: next fetch 0x200.
        wait_ifv("tmo_if100");
        exp_if.push_back(32'h100);
        exp_req.push_back(32'h200);
        redirect_valid  = 1'b1;
        redirect_target = 32'h200;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        @(negedge clk);
        check_eq("hold_redir_req", 32'(imem_req_valid), 32'd1);
        check_eq("hold_redir_addr", imem_req_addr, 32'h200);
        check_eq("flush_hold", 32'(flush_decode), 32'd1);

        // Redirect in REQ while memory stalls: old address held, then target.
        wait_ifv("tmo_if200");
        exp_if.push_back(32'h200);
        exp_req.push_back(32'h204);
        exp_req.push_back(32'h300);
        imem_req_ready = 1'b0;
        @(posedge clk); #1;
        redirect_valid  = 1'b1;
        redirect_target = 32'h300;
        @(negedge clk);
        check_eq("stall_req_valid", 32'(imem_req_valid), 32'd1);
        check_eq("stall_req_addr0", imem_req_addr, 32'h204);
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        @(negedge clk);
        check_eq("stall_req_addr1", imem_req_addr, 32'h204);
        check_eq("flush_req", 32'(flush_decode), 32'd1);
        @(posedge clk); #1;
        imem_req_ready = 1'b1;
        if_ready       = 1'b0;
        wait_ifv("tmo_if300");
        check_eq("pc_after_req_redir", if_pc, 32'h300);

        // Misaligned target 0x102.
        redirect_valid  = 1'b1;
        redirect_target = 32'h102;
`ifdef MISALIGN_TRAP_EN
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        @(negedge clk);
        check_eq("trap_valid", 32'(trap_valid), 32'd1);
        check_eq("trap_addr", trap_addr, 32'h102);
        check_eq("flush_trap", 32'(flush_decode), 32'd1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_eq("halt_no_req", 32'(imem_req_valid), 32'd0);
            check_eq("halt_no_if", 32'(if_valid), 32'd0);
        end
        check_eq("trap_held", 32'(trap_valid), 32'd1);
`else
        exp_req.push_back(32'h100);
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        @(negedge clk);
        check_eq("flush_misalign", 32'(flush_decode), 32'd1);
        check_eq("no_trap", 32'(trap_valid), 32'd0);
        check_eq("no_trap_addr", trap_addr, 32'h0);
        check_eq("trunc_req", 32'(imem_req_valid), 32'd1);
        check_eq("trunc_addr", imem_req_addr, 32'h100);
        repeat (4) @(negedge clk);
`endif
        check_eq("req_queue_empty", 32'(exp_req.size()), 32'd0);
        check_eq("if_queue_empty", 32'(exp_if.size()), 32'd0);

        // Reset from a busy state returns to idle and clears the trap.
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("rerst_req_valid", 32'(imem_req_valid), 32'd0);
        check_eq("rerst_if_valid", 32'(if_valid), 32'd0);
        check_eq("rerst_trap", 32'(trap_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
